l2_mem_responder: RTL and testbench
===================================

Name: l2_mem_responder

Overview:
Memory-side responder for the generic_bus protocol. It serves the read and write requests that the L2 cache issues on its memory port during FETCH, WB and FLUSH. The block holds a word-addressed backing store with a parameterised wait-state count, so cache fill, writeback and flush traffic can be exercised against realistic latency. It sits between the L2 memory port and the system memory map, and also acts as the simulation/FPGA main memory.

Parameters:
DEPTH, 1024, number of 32-bit words in the backing store (power of 2)
LATENCY, 2, wait-state cycles between request acceptance and completion (0..15)
BASE_ADDR, 32'h0000_0000, byte address that maps to word 0
BAD_DATA, 32'hBAD1_BAD1, rdata returned for out-of-range reads

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
bus_if.addr  input  32  byte address from the L2 memory port
bus_if.wdata  input  32  write data
bus_if.ren  input  1  read request
bus_if.wen  input  1  write request
bus_if.byte_en  input  4  byte lanes for writes
bus_if.rdata  output  32  read data
bus_if.busy  output  1  low for exactly one cycle when the access completes
(bus_if is the generic_bus_if responder-side modport. The clock is CLK. Reset is RST: one clock, asynchronous, active-high.)

Behaviour:
- Reset (async on RST high): state=IDLE, busy=1, rdata=0, wait counter=0, latched address/data/byte_en=0, all store words=0.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - On (ren|wen) sampled high, latch addr, wdata, byte_en and op. wen has priority when both are high (the access is a write).
  - Load counter=LATENCY-1 and go to WAIT. If LATENCY=0, go directly to RESPOND.
  - busy=1.
- WAIT: decrement counter; at counter==0 go to RESPOND. busy=1.
- RESPOND:
  - busy=0 for this one cycle.
  - For a read, rdata=store[idx] is driven combinationally during this cycle and held registered afterwards until the next read completes.
  - For a write, the word is updated at the end of this cycle, only on lanes where byte_en[i]=1.
  - Next state is always IDLE.
- Latency: request first sampled at cycle N, busy=0 at cycle N+LATENCY+1.
- Back-to-back: the requester drops ren/wen in the cycle after busy=0. If the request is still high in IDLE, it is accepted as a new transaction. Minimum spacing is LATENCY+2 cycles.
- Word index: idx=(addr-BASE_ADDR)>>2, modulo-2^32 subtraction. addr[1:0] is ignored.
- Out of range (idx>=DEPTH, including addr<BASE_ADDR through wrap-around):
  - Read returns BAD_DATA.
  - Write is dropped.
  - Timing is identical to an in-range access.
- Mid-transaction changes: changes to addr, wdata, byte_en or ren/wen after acceptance are ignored. Deasserting the request during WAIT does not abort; the access still completes and a write still commits.
- Reset asserted mid-transaction: FSM returns to IDLE and busy=1. No partial write occurs. The store clears to 0.
- byte_en=0 write completes normally with no change to the store.

Optional Feature:
MEM_RESP_ERROR_EN:
- Defined: adds output port bus_err (1 bit, reset 0). bus_err is asserted only in the RESPOND cycle, alongside busy=0, for:
  - out-of-range accesses;
  - requests accepted with ren and wen both high (still executed as a write).
  An internal 16-bit saturating counter err_count, visible hierarchically, increments on each flagged access.
- Undefined: no bus_err port and no counter. Error conditions complete silently as described in Behaviour.

Test Plan:
- LATENCY=2: write 32'hDEAD_BEEF to 0x0000_0010 with byte_en=4'hF, then read 0x10 -> busy=0 exactly 3 cycles after each request; read returns 32'hDEAD_BEEF.
- Partial write: word 0x20 = 32'h1122_3344, then write 32'hAAAA_AAAA with byte_en=4'b0101 -> read returns 32'h11AA_33AA.
- Out of range: read at BASE_ADDR + DEPTH*4 -> rdata=32'hBAD1_BAD1, busy timing unchanged. Write there followed by a read of word 0 -> word 0 unchanged. With MEM_RESP_ERROR_EN, bus_err=1 in both completion cycles.
- Mid-transaction changes: change addr and drop ren one cycle after acceptance -> completion still occurs for the original address with its data. Ren held one cycle past busy=0 -> a second access starts and completes LATENCY+1 cycles later.
- LATENCY=0: 8-word burst of separate writes then reads, modelling an L2 block fill/writeback -> each busy=0 one cycle after its request; all 8 words read back correctly.
- Reset mid-operation: assert RST during WAIT of a write of 32'h5555_5555 -> busy=1 and state IDLE immediately; subsequent read of that address returns 0.

Source files
------------

// File: rtl/l2_mem_responder_if.sv
// generic_bus request/response signals between the L2 memory port (master)
// and the memory-side responder (slave).
interface generic_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ren;
  logic        wen;
  logic        busy;
  logic [3:0]  byte_en;

  modport master (
    output addr, wdata, ren, wen, byte_en,
    input  rdata, busy
  );

  modport slave (
    input  addr, wdata, ren, wen, byte_en,
    output rdata, busy
  );
endinterface

// File: rtl/l2_mem_responder.sv
// Word-addressed backing store serving L2 FETCH/WB/FLUSH traffic with LATENCY wait states.
// Optional MEM_RESP_ERROR_EN adds bus_err and a saturating err_count.
module l2_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] BAD_DATA  = 32'hBAD1_BAD1
) (
  input  logic          CLK,
  input  logic          RST,
  generic_bus_if.slave  bus_if
`ifdef MEM_RESP_ERROR_EN
  ,
  output logic          bus_err
`endif
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StRespond} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic        write_q, both_q;
  logic [31:0] mem_q [DEPTH];

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          accept, respond;

  // Modulo-2^32 offset makes addresses below BASE_ADDR wrap to out of range.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = {2'b00, offset[31:2]} < DEPTH;
  assign idx      = offset[AW+1:2];
  assign rd_word  = in_range ? mem_q[idx] : BAD_DATA;
  assign accept   = (state_q == StIdle) && (bus_if.ren || bus_if.wen);
  assign respond  = (state_q == StRespond);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_if.ren || bus_if.wen) begin
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 0) ? StRespond : StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StRespond;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_if.busy  = !respond;
    bus_if.rdata = (respond && !write_q) ? rd_word : rdata_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
      both_q  <= 1'b0;
      rdata_q <= 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        addr_q  <= bus_if.addr;
        wdata_q <= bus_if.wdata;
        be_q    <= bus_if.byte_en;
        write_q <= bus_if.wen;
        both_q  <= bus_if.ren && bus_if.wen;
      end
      if (respond) begin
        if (!write_q) begin
          rdata_q <= rd_word;
        end else if (in_range) begin
          for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

`ifdef MEM_RESP_ERROR_EN
  logic        err_flag;
  logic [15:0] err_count;

  assign err_flag = !in_range || both_q;

  always_comb begin
    bus_err = respond && err_flag;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_count <= 16'd0;
    end else if (respond && err_flag && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Scoreboard bench: two responders (LATENCY=2 at base 0, LATENCY=0 at a high base) driven with
// directed and random traffic; a negedge monitor checks completion timing, rdata and held rdata.
module tb_l2_mem_responder;

  localparam int          L0 = 2;
  localparam int          D0 = 64;
  localparam logic [31:0] B0 = 32'h0000_0000;
  localparam int          L1 = 0;
  localparam int          D1 = 16;
  localparam logic [31:0] B1 = 32'h8000_0000;
  localparam logic [31:0] BAD = 32'hBAD1_BAD1;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  generic_bus_if b0 ();
  generic_bus_if b1 ();

`ifdef MEM_RESP_ERROR_EN
  logic err0, err1;
`endif

  l2_mem_responder #(.DEPTH(D0), .LATENCY(L0), .BASE_ADDR(B0), .BAD_DATA(BAD)) dut0 (
    .CLK    (CLK),
    .RST    (RST),
    .bus_if (b0)
`ifdef MEM_RESP_ERROR_EN
    ,
    .bus_err(err0)
`endif
  );

  l2_mem_responder #(.DEPTH(D1), .LATENCY(L1), .BASE_ADDR(B1), .BAD_DATA(BAD)) dut1 (
    .CLK    (CLK),
    .RST    (RST),
    .bus_if (b1)
`ifdef MEM_RESP_ERROR_EN
    ,
    .bus_err(err1)
`endif
  );

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          done;
    bit          err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m0 [D0];
  logic [31:0] m1 [D1];
  logic [31:0] hold0 = 32'd0;
  logic [31:0] hold1 = 32'd0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: flat word arrays, byte-lane merge, range from modulo offset.
  function automatic exp_t model(int w, bit ren, bit wen, logic [31:0] a, logic [31:0] d,
                                 logic [3:0] be);
    exp_t        e;
    logic [31:0] off;
    logic [31:0] word;
    int          idx;
    bit          inr;
    off  = a - ((w == 1) ? B1 : B0);
    idx  = int'(off >> 2);
    inr  = idx < ((w == 1) ? D1 : D0);
    word = BAD;
    if (inr) word = (w == 1) ? m1[idx[3:0]] : m0[idx[5:0]];
    e.rd   = !wen;
    e.err  = !inr || (ren && wen);
    e.done = 0;
    e.data = 32'd0;
    if (!wen) begin
      e.data = word;
    end else if (inr) begin
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
      if (w == 1) m1[idx[3:0]] = word;
      else        m0[idx[5:0]] = word;
    end
    return e;
  endfunction

  task automatic drive(int w, bit ren, bit wen, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    if (w == 1) begin
      b1.ren = ren; b1.wen = wen; b1.addr = a; b1.wdata = d; b1.byte_en = be;
    end else begin
      b0.ren = ren; b0.wen = wen; b0.addr = a; b0.wdata = d; b0.byte_en = be;
    end
  endtask

  function automatic logic busy_of(int w);
    return (w == 1) ? b1.busy : b0.busy;
  endfunction

  task automatic access(int w, bit ren, bit wen, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                        bit mangle, bit keep);
    exp_t e;
    int   t;
    @(negedge CLK);
    drive(w, ren, wen, a, d, be);
    e      = model(w, ren, wen, a, d, be);
    e.done = cyc + ((w == 1) ? L1 : L0) + 1;
    if (w == 1) q1.push_back(e);
    else        q0.push_back(e);
    if (mangle) begin
      @(negedge CLK);
      drive(w, 1'b0, 1'b0, a ^ 32'h44, ~d, ~be);
    end
    t = 0;
    while (busy_of(w) && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL completion_timeout: dut%0d busy still 1 after %0d cycles, expected 0", w, t);
    end
    if (!keep) drive(w, 1'b0, 1'b0, a, d, be);
  endtask

  task automatic mon(int w, logic busy, logic [31:0] rdata, logic err);
    exp_t e;
    int   qs;
    qs = (w == 1) ? q1.size() : q0.size();
    if (!busy) begin
      if (qs == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: dut%0d busy=0 at cycle %0d, expected 1", w, cyc);
      end else begin
        e = (w == 1) ? q1.pop_front() : q0.pop_front();
        chk($sformatf("done_cycle_dut%0d", w), 32'(cyc), 32'(e.done));
        if (e.rd) begin
          chk($sformatf("rdata_dut%0d", w), rdata, e.data);
          if (w == 1) hold1 = e.data;
          else        hold0 = e.data;
        end
`ifdef MEM_RESP_ERROR_EN
        chk($sformatf("bus_err_dut%0d", w), {31'd0, err}, {31'd0, e.err});
`endif
      end
    end else begin
      chk($sformatf("rdata_hold_dut%0d", w), rdata, (w == 1) ? hold1 : hold0);
`ifdef MEM_RESP_ERROR_EN
      chk($sformatf("bus_err_idle_dut%0d", w), {31'd0, err}, 32'd0);
`endif
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
`ifdef MEM_RESP_ERROR_EN
      mon(0, b0.busy, b0.rdata, err0);
      mon(1, b1.busy, b1.rdata, err1);
`else
      mon(0, b0.busy, b0.rdata, 1'b0);
      mon(1, b1.busy, b1.rdata, 1'b0);
`endif
    end
  end

  task automatic clear_model();
    for (int i = 0; i < D0; i++) m0[i] = 32'd0;
    for (int i = 0; i < D1; i++) m1[i] = 32'd0;
    hold0 = 32'd0;
    hold1 = 32'd0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w, op, idx;
    logic [31:0] a;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    clear_model();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset_busy0", {31'd0, b0.busy}, 32'd1);
    chk("reset_busy1", {31'd0, b1.busy}, 32'd1);
    chk("reset_rdata0", b0.rdata, 32'd0);
    chk("reset_rdata1", b1.rdata, 32'd0);
    RST = 1'b0;

    // Full write/read, partial write, out of range, ren+wen collision.
    access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0);
    access(0, 0, 1, 32'h20, 32'h1122_3344, 4'hF, 0, 0);
    access(0, 0, 1, 32'h20, 32'hAAAA_AAAA, 4'b0101, 0, 0);
    access(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 0);
    access(0, 0, 1, 32'h0, 32'h7777_0001, 4'hF, 0, 0);
    access(0, 1, 0, B0 + D0 * 4, 32'h0, 4'h0, 0, 0);
    access(0, 0, 1, B0 + D0 * 4, 32'h1234_5678, 4'hF, 0, 0);
    access(0, 1, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    access(0, 1, 1, 32'h44, 32'h0BAD_CAFE, 4'hF, 0, 0);
    access(0, 1, 0, 32'h47, 32'h0, 4'h0, 0, 0);
    access(0, 0, 1, 32'h3C, 32'hFFFF_FFFF, 4'h0, 0, 0);
    access(0, 1, 0, 32'h3C, 32'h0, 4'h0, 0, 0);

    // Request changes after acceptance are ignored; held request starts a second access.
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 1, 0);
    access(0, 0, 1, 32'h54, 32'hCAFE_F00D, 4'hF, 1, 0);
    access(0, 1, 0, 32'h54, 32'h0, 4'h0, 0, 0);
    access(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 1);
    access(0, 1, 0, 32'h20, 32'h0, 4'h0, 0, 0);

    // Zero-latency block fill then readback, including a below-base wrap.
    for (int i = 0; i < 8; i++) access(1, 0, 1, B1 + 32'(i * 4), $urandom, 4'hF, 0, 0);
    for (int i = 0; i < 8; i++) access(1, 1, 0, B1 + 32'(i * 4), 32'h0, 4'h0, 0, 0);
    access(1, 1, 0, B1 - 32'd4, 32'h0, 4'h0, 0, 0);

    // Reset in WAIT of a write: no commit, store cleared.
    @(negedge CLK);
    drive(0, 1'b0, 1'b1, 32'h30, 32'h5555_5555, 4'hF);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midreset_busy0", {31'd0, b0.busy}, 32'd1);
    chk("midreset_rdata0", b0.rdata, 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    clear_model();
    @(negedge CLK);
    RST = 1'b0;
    access(0, 1, 0, 32'h30, 32'h0, 4'h0, 0, 0);
    access(0, 1, 0, 32'h10, 32'h0, 4'h0, 0, 0);

    for (int n = 0; n < 160; n++) begin
      w   = int'($urandom_range(0, 1));
      op  = int'($urandom_range(0, 2));
      idx = int'($urandom_range(0, ((w == 1) ? D1 : D0) + 2));
      a   = ((w == 1) ? B1 : B0) + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = ((w == 1) ? B1 : B0) - 32'(4 * $urandom_range(1, 4));
      access(w, op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)),
             (w == 0) && ($urandom_range(0, 5) == 0), 0);
    end

    repeat (4) @(negedge CLK);
    chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
